scope_capture_mc: RTL
=====================

Name: scope_capture_mc

Overview:
Parametrised multi-channel triggered capture engine, the next-generation acquisition front end for the VGA oscilloscope. Decimates incoming ADC samples and stores them in a circular buffer. Detects a level/edge trigger with a programmable pre-trigger depth, then freezes a complete frame. The display path reads the frozen frame through a registered random-access port while capture is held.

Parameters:
NCH, 2, number of input channels
SW, 16, sample width; unsigned offset-binary (midscale 2^(SW-1))
DEPTH, 512, frame length in samples per channel; power of two
AW, 9, log2(DEPTH)
PRE, 128, pre-trigger samples in frame; 1 <= PRE <= DEPTH-2
DEC_W, 8, width of decimation control
AUTO_TO, 4096, auto-mode timeout in decimated samples

Ports:
CLOCK_50  in  1  sole clock; all logic on rising edge
reset  in  1  synchronous, active-high
sample_valid  in  1  qualifies signal this cycle
signal  in  NCH*SW  channel k at bits [k*SW +: SW]
decim  in  DEC_W  keep 1 of every decim+1 valid samples
trig_ch  in  max(1,clog2(NCH))  trigger source channel
trig_level  in  SW  trigger threshold
trig_rising  in  1  1 = rising edge, 0 = falling edge
mode  in  2  00 auto, 01 normal, 10 single, 11 treated as normal
arm  in  1  pulse; starts capture from IDLE or HOLD(single)
frame_ack  in  1  pulse; display done, release HOLD (auto/normal)
rd_ch  in  max(1,clog2(NCH))  read channel
rd_addr  in  AW  frame-relative index; 0 = oldest pre-trigger sample
rd_data  out  SW  registered, 1-cycle latency
frame_ready  out  1  high in HOLD
busy  out  1  high in PREFILL/ARMED/POST
triggered  out  1  1 = real trigger, 0 = forced by auto timeout; valid while frame_ready

Behaviour:
- Reset values: state IDLE, rd_data 0, frame_ready 0, busy 0, triggered 0; write pointer, counters, and decimation counter cleared. Memory is not cleared.
- Decimation:
  - Counter counts valid samples; when count == decim, the sample is "kept" and the counter reloads to 0.
  - A decim change takes effect at the next reload.
  - sample_valid low stalls everything except reads.
- Kept samples of all channels are written at wr_ptr, and wr_ptr increments mod DEPTH (wraps 511 -> 0). Writes occur only in PREFILL, ARMED, and POST.
- States:
  - IDLE: in auto/normal, go to PREFILL next cycle; in single, wait for arm.
  - PREFILL: write PRE kept samples, then go to ARMED. Trigger is not evaluated.
  - ARMED: write continuously. Edge compare on trig_ch uses the previous kept sample (prev) and the current kept sample (cur):
    - rising trigger: prev < trig_level && cur >= trig_level
    - falling trigger: prev > trig_level && cur <= trig_level
  - Trigger in ARMED: record trig_addr = write address of cur, set triggered=1, go to POST.
  - Auto mode only: if AUTO_TO kept samples pass in ARMED without a trigger, force a trigger on that sample with triggered=0.
  - prev updates on every kept sample in any writing state, so the first ARMED compare is valid.
  - POST: write DEPTH-PRE-1 further kept samples, then go to HOLD. Frame = DEPTH samples with the trigger sample at index PRE.
  - HOLD: frame_ready=1, no writes.
    - auto/normal: frame_ack goes to PREFILL.
    - single: frame_ack is ignored; arm goes to PREFILL.
- A mode change is sampled only on the IDLE/HOLD exit.
- arm in a busy state is ignored. arm and frame_ack in the same cycle in HOLD count as one release.
- Read: physical address = (trig_addr - PRE + rd_addr) mod DEPTH on channel rd_ch; rd_data is valid the cycle after the address is presented. Reads are legal in any state but guaranteed coherent only while frame_ready=1.
- reset in any state, including mid-POST: go to IDLE next cycle; the partially captured frame is discarded (frame_ready 0).

Optional Feature:
SCOPE_PEAKDET_EN
- Defined: each channel stores the maximum valid sample seen within the decimation window instead of the last one. The window accumulator resets at each kept sample. The trigger compares use the stored (peak) values.
- Undefined: plain sub-sampling, no accumulator logic.
- With decim=0, both builds are identical.

Test Plan:
- Normal, rising, level 1000, decim 0; ch0 ramp 0,1,2..., ch1 = ch0+5000 -> trigger on value 1000; then:
  - rd ch0: addr 128 = 1000, addr 0 = 872, addr 511 = 1383
  - rd ch1: addr 128 = 6000
  - frame_ready rises 383 kept samples after the trigger; triggered=1
- Falling trigger, level 30000, ch0 descending ramp from 40000, trig_ch=0 -> rd addr 128 = 30000; repeat with trig_ch=1 and ch1 driving the edge.
- Auto mode, constant input 32768, level 40000 -> forced frame after PREFILL + 4096 kept samples; triggered=0; all rd_data 32768.
- decim=3, ramp input, rising level 400 -> stored values step by 4; rd addr 128 = 400, addr 127 = 396; sample_valid toggled 50% produces identical content.
- Single mode: capture completes; frame_ack pulse leaves frame_ready=1 and data unchanged; arm pulse -> busy=1 next cycle; reset asserted mid-POST -> IDLE, frame_ready=0, no HOLD until arm.
- SCOPE_PEAKDET_EN, decim=3, input repeating 10,90,20,30 -> every stored sample = 90.

Source files
------------

// File: rtl/scope_capture_mc.sv
// scope_capture_mc: multi-channel triggered capture engine.
// Decimates ADC samples into a circular buffer per channel, detects a
// level/edge trigger after a pre-trigger fill, freezes a frame of DEPTH
// samples (trigger at index PRE) and serves it through a registered read port.
// Optional build macro: SCOPE_PEAKDET_EN (peak-hold within decimation window).
module scope_capture_mc #(
  parameter int NCH     = 2,
  parameter int SW      = 16,
  parameter int DEPTH   = 512,
  parameter int AW      = 9,
  parameter int PRE     = 128,
  parameter int DEC_W   = 8,
  parameter int AUTO_TO = 4096,
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [NCH*SW-1:0] signal,
  input  logic [DEC_W-1:0]  decim,
  input  logic [CW-1:0]     trig_ch,
  input  logic [SW-1:0]     trig_level,
  input  logic              trig_rising,
  input  logic [1:0]        mode,
  input  logic              arm,
  input  logic              frame_ack,
  input  logic [CW-1:0]     rd_ch,
  input  logic [AW-1:0]     rd_addr,
  output logic [SW-1:0]     rd_data,
  output logic              frame_ready,
  output logic              busy,
  output logic              triggered
);

  localparam int CNT_W = $clog2(AUTO_TO + DEPTH) + 1;
  localparam logic [1:0] M_AUTO   = 2'b00;
  localparam logic [1:0] M_SINGLE = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PREFILL = 3'd1,
    S_ARMED   = 3'd2,
    S_POST    = 3'd3,
    S_HOLD    = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [DEC_W-1:0]  dec_cnt_q, dec_q;
  logic              keep_s, writing_s, we_s;
  logic [NCH*SW-1:0] wr_word_s;
  logic [SW-1:0]     cur_s, prev_q;
  logic              edge_s, timeout_s, fire_s;
  logic [CNT_W-1:0]  cnt_q;
  logic [AW-1:0]     wr_ptr_q, trig_addr_q, rd_phys_s;
  logic              triggered_q, frame_ready_q, busy_q;
  logic              frame_ready_d, busy_d;
  logic [SW-1:0]     rd_data_q;
  logic [NCH*SW-1:0] mem_q [DEPTH];

  // A sample is kept when the window counter reaches the latched decimation
  // ratio; the latched ratio only changes at a reload so windows stay whole.
  assign keep_s    = sample_valid && (dec_cnt_q == dec_q);
  assign writing_s = (state_q == S_PREFILL) || (state_q == S_ARMED) || (state_q == S_POST);
  assign we_s      = keep_s && writing_s;

`ifdef SCOPE_PEAKDET_EN
  logic [NCH*SW-1:0] acc_q;

  // Stored value per channel is the maximum of the window so far and this sample.
  always_comb begin
    wr_word_s = signal;
    for (int k = 0; k < NCH; k++) begin
      if (acc_q[k*SW +: SW] > signal[k*SW +: SW]) begin
        wr_word_s[k*SW +: SW] = acc_q[k*SW +: SW];
      end else begin
        wr_word_s[k*SW +: SW] = signal[k*SW +: SW];
      end
    end
  end

  // Window peak accumulator; restarts after every kept sample.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      acc_q <= '0;
    end else if (keep_s) begin
      acc_q <= '0;
    end else if (sample_valid) begin
      acc_q <= wr_word_s;
    end
  end
`else
  assign wr_word_s = signal;
`endif

  // Trigger evaluation on the selected channel, using the stored values.
  always_comb begin
    cur_s     = wr_word_s[int'(trig_ch)*SW +: SW];
    edge_s    = trig_rising ? ((prev_q < trig_level) && (cur_s >= trig_level))
                            : ((prev_q > trig_level) && (cur_s <= trig_level));
    timeout_s = (mode_q == M_AUTO) && (cnt_q == CNT_W'(AUTO_TO - 1));
    fire_s    = (state_q == S_ARMED) && we_s && (edge_s || timeout_s);
    rd_phys_s = trig_addr_q - AW'(PRE) + rd_addr;
  end

  // FSM state register; mode is captured only when leaving IDLE or HOLD.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q <= S_IDLE;
      mode_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if ((mode != M_SINGLE) || arm) begin
          state_d = S_PREFILL;
          mode_d  = mode;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PREFILL: begin
        if (we_s && (cnt_q == CNT_W'(PRE - 1))) state_d = S_ARMED;
        else                                    state_d = S_PREFILL;
      end
      S_ARMED: begin
        if (fire_s) state_d = S_POST;
        else        state_d = S_ARMED;
      end
      S_POST: begin
        if (we_s && (cnt_q == CNT_W'(DEPTH - PRE - 2))) state_d = S_HOLD;
        else                                            state_d = S_POST;
      end
      S_HOLD: begin
        if ((mode_q == M_SINGLE) ? arm : frame_ack) begin
          state_d = S_PREFILL;
          mode_d  = mode;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FSM output decode from the next state so status flags can be registered.
  always_comb begin
    busy_d        = 1'b0;
    frame_ready_d = 1'b0;
    case (state_d)
      S_PREFILL, S_ARMED, S_POST: busy_d        = 1'b1;
      S_HOLD:                     frame_ready_d = 1'b1;
      default: begin
        busy_d        = 1'b0;
        frame_ready_d = 1'b0;
      end
    endcase
  end

  // Decimation, write pointer, phase counter, trigger capture, status and read port.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      dec_cnt_q     <= '0;
      dec_q         <= '0;
      wr_ptr_q      <= '0;
      cnt_q         <= '0;
      prev_q        <= '0;
      trig_addr_q   <= '0;
      triggered_q   <= 1'b0;
      frame_ready_q <= 1'b0;
      busy_q        <= 1'b0;
      rd_data_q     <= '0;
    end else begin
      if (keep_s) begin
        dec_cnt_q <= '0;
        dec_q     <= decim;
      end else if (sample_valid) begin
        dec_cnt_q <= dec_cnt_q + DEC_W'(1);
      end
      if (we_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
        prev_q   <= cur_s;
      end
      if (state_d != state_q) begin
        cnt_q <= '0;
      end else if (we_s) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (fire_s) begin
        trig_addr_q <= wr_ptr_q;
        triggered_q <= edge_s;
      end
      frame_ready_q <= frame_ready_d;
      busy_q        <= busy_d;
      rd_data_q     <= mem_q[rd_phys_s][int'(rd_ch)*SW +: SW];
    end
  end

  // Sample memory: all channels of a kept sample share one word; never cleared.
  always_ff @(posedge CLOCK_50) begin
    if (we_s) mem_q[wr_ptr_q] <= wr_word_s;
  end

  assign rd_data     = rd_data_q;
  assign frame_ready = frame_ready_q;
  assign busy        = busy_q;
  assign triggered   = triggered_q;

endmodule
